// File: rtl/core_run_controller_pkg.sv
// Shared types and default constants for the core run controller.
// Imported by the controller top and its testbench.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RELEASE,
        RUN,
        DONE
    } run_state_t;

    localparam int         DEF_MAX_CYCLES = 100000;
    localparam logic [9:0] DEF_HALT_ADDR  = 10'h3FF;

endpackage

// File: rtl/core_run_controller_if.sv
// Program-load stream between the host and the run controller.
// The host is the master; the controller is the slave.
interface core_run_controller_if #(
    parameter int DATA_SIZE = 32
);
    logic                 load_valid;
    logic                 load_ready;
    logic [DATA_SIZE-1:0] load_data;
    logic                 load_last;

    modport master (output load_valid, output load_data, output load_last, input load_ready);
    modport slave  (input load_valid, input load_data, input load_last, output load_ready);
endinterface

// File: rtl/core_run_controller_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones.
// Serves as the RUN cycle counter and as the program load pointer.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/core_run_controller.sv
// Sequences the core through program load, execution and halt detection.
// Holds the core in reset except while running; gates the halt store off the data memory.
module core_run_controller
    import run_ctrl_pkg::*;
#(
    parameter int                   ADDR_SIZE  = 10,
    parameter int                   DATA_SIZE  = 32,
    parameter int                   CNT_W      = 32,
    parameter int                   MAX_CYCLES = DEF_MAX_CYCLES,
    parameter logic [ADDR_SIZE-1:0] HALT_ADDR  = ADDR_SIZE'(DEF_HALT_ADDR)
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  start,
    input  logic                  abort,
    core_run_controller_if.slave  ld,
    output logic                  imem_we,
    output logic [ADDR_SIZE-1:0]  imem_waddr,
    output logic [DATA_SIZE-1:0]  imem_wdata,
    output logic                  core_rst_n,
    input  logic [ADDR_SIZE-1:0]  core_daddr,
    input  logic [DATA_SIZE-1:0]  core_ddata_w,
    input  logic                  core_mem_write,
    output logic                  dmem_we,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic                  overflow,
    output logic [DATA_SIZE-1:0]  exit_code,
    output logic [CNT_W-1:0]      cycle_count
);

    run_state_t           r_state;
    run_state_t           w_next;
    logic                 w_start_ok;
    logic                 w_hs;
    logic                 w_ovf_hit;
    logic                 w_halt_hit;
    logic                 w_budget_hit;
    logic [ADDR_SIZE-1:0] w_ptr;
    logic [CNT_W-1:0]     w_cnt;

    logic                 r_imem_we;
    logic [ADDR_SIZE-1:0] r_imem_waddr;
    logic [DATA_SIZE-1:0] r_imem_wdata;
    logic                 r_timeout;
    logic                 r_overflow;
    logic [DATA_SIZE-1:0] r_exit_code;

    assign w_start_ok   = start & ((r_state == IDLE) | (r_state == DONE));
    assign w_hs         = ld.load_valid & (r_state == LOAD);
    // Running off the top of the address space ends the load as if last were set.
    assign w_ovf_hit    = w_hs & ~ld.load_last & (w_ptr == '1);
    assign w_halt_hit   = core_mem_write & (core_daddr == HALT_ADDR);
    assign w_budget_hit = (w_cnt == CNT_W'(MAX_CYCLES - 1));

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .i_clr   (w_start_ok),
        .i_en    (r_state == RUN),
        .o_cnt   (w_cnt)
    );

    sat_counter #(.W(ADDR_SIZE)) u_load_ptr (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .i_clr   (w_start_ok),
        .i_en    (w_hs),
        .o_cnt   (w_ptr)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        ld.load_ready = 1'b0;
        core_rst_n    = 1'b0;
        dmem_we       = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = LOAD;
            end
            LOAD: begin
                ld.load_ready = 1'b1;
                busy          = 1'b1;
                if (abort) w_next = IDLE;
                else if (w_hs & (ld.load_last | w_ovf_hit)) w_next = RELEASE;
            end
            RELEASE: begin
                busy   = 1'b1;
                w_next = abort ? IDLE : RUN;
            end
            RUN: begin
                busy       = 1'b1;
                core_rst_n = 1'b1;
                dmem_we    = core_mem_write & ~w_halt_hit;
                if (abort) w_next = IDLE;
                else if (w_halt_hit | w_budget_hit) w_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) w_next = LOAD;
            end
            default: w_next = IDLE;
        endcase
    end

    // Abort drops any accepted word and leaves every status register untouched.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_imem_we    <= 1'b0;
            r_imem_waddr <= '0;
            r_imem_wdata <= '0;
            r_timeout    <= 1'b0;
            r_overflow   <= 1'b0;
            r_exit_code  <= '0;
        end else begin
            r_imem_we <= w_hs & ~abort;
            if (w_hs & ~abort) begin
                r_imem_waddr <= w_ptr;
                r_imem_wdata <= ld.load_data;
            end
            if (w_start_ok) begin
                r_timeout   <= 1'b0;
                r_overflow  <= 1'b0;
                r_exit_code <= '0;
            end
            if (w_ovf_hit & ~abort) r_overflow <= 1'b1;
            if ((r_state == RUN) & ~abort) begin
                if (w_halt_hit) r_exit_code <= core_ddata_w;
                else if (w_budget_hit) r_timeout <= 1'b1;
            end
        end
    end

    assign imem_we     = r_imem_we;
    assign imem_waddr  = r_imem_waddr;
    assign imem_wdata  = r_imem_wdata;
    assign timeout     = r_timeout;
    assign overflow    = r_overflow;
    assign exit_code   = r_exit_code;
    assign cycle_count = w_cnt;

endmodule

// File: tb/tb_core_run_controller.sv
// Self-checking bench for core_run_controller: directed scenarios plus randomized
// load/run episodes, checked each cycle against a behavioural model.
module tb_core_run_controller;

    localparam int         AW = 2;
    localparam int         DW = 32;
    localparam int         CW = 32;
    localparam int         MC = 16;
    localparam logic [1:0] HA = 2'h3;
    localparam int         NWORDS = 1 << AW;

    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_REL  = 2;
    localparam int PH_RUN  = 3;
    localparam int PH_DONE = 4;

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic          start, abort;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [DW-1:0] imem_wdata;
    logic          core_rst_n;
    logic [AW-1:0] core_daddr;
    logic [DW-1:0] core_ddata_w;
    logic          core_mem_write;
    logic          dmem_we, busy, done, timeout, overflow;
    logic [DW-1:0] exit_code;
    logic [CW-1:0] cycle_count;

    core_run_controller_if #(.DATA_SIZE(DW)) lif ();

    core_run_controller #(
        .ADDR_SIZE (AW),
        .DATA_SIZE (DW),
        .CNT_W     (CW),
        .MAX_CYCLES(MC),
        .HALT_ADDR (HA)
    ) dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .start         (start),
        .abort         (abort),
        .ld            (lif),
        .imem_we       (imem_we),
        .imem_waddr    (imem_waddr),
        .imem_wdata    (imem_wdata),
        .core_rst_n    (core_rst_n),
        .core_daddr    (core_daddr),
        .core_ddata_w  (core_ddata_w),
        .core_mem_write(core_mem_write),
        .dmem_we       (dmem_we),
        .busy          (busy),
        .done          (done),
        .timeout       (timeout),
        .overflow      (overflow),
        .exit_code     (exit_code),
        .cycle_count   (cycle_count)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: phase, load pointer, pending write and status.
    int          m_ph;
    int          m_ptr;
    bit          m_we;
    int          m_wa;
    logic [31:0] m_wd;
    bit          m_to, m_ov;
    logic [31:0] m_exit;
    longint      m_cnt;

    task automatic m_reset();
        m_ph = PH_IDLE; m_ptr = 0; m_we = 0; m_wa = 0; m_wd = '0;
        m_to = 0; m_ov = 0; m_exit = '0; m_cnt = 0;
    endtask

    task automatic m_step();
        bit write_next;
        bit halt;
        bit budget;
        write_next = 0;
        case (m_ph)
            PH_IDLE, PH_DONE: begin
                if (start) begin
                    m_ph = PH_LOAD; m_ptr = 0; m_to = 0; m_ov = 0; m_exit = '0; m_cnt = 0;
                end
            end
            PH_LOAD: begin
                if (abort) m_ph = PH_IDLE;
                else if (lif.load_valid) begin
                    write_next = 1; m_wa = m_ptr; m_wd = lif.load_data;
                    if (lif.load_last) m_ph = PH_REL;
                    else if (m_ptr == NWORDS - 1) begin m_ov = 1; m_ph = PH_REL; end
                    else m_ptr = m_ptr + 1;
                end
            end
            PH_REL: m_ph = abort ? PH_IDLE : PH_RUN;
            PH_RUN: begin
                halt   = core_mem_write && (core_daddr == HA);
                budget = (m_cnt == MC - 1);
                if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
                if (abort) m_ph = PH_IDLE;
                else if (halt) begin m_exit = core_ddata_w; m_ph = PH_DONE; end
                else if (budget) begin m_to = 1; m_ph = PH_DONE; end
            end
            default: m_ph = PH_IDLE;
        endcase
        m_we = write_next;
    endtask

    always @(negedge CLK) begin
        bit e_dmem;
        if (!RESET_N) m_reset();
        e_dmem = (m_ph == PH_RUN) && core_mem_write && (core_daddr != HA);
        cmp("load_ready",  64'(lif.load_ready), 64'(m_ph == PH_LOAD));
        cmp("core_rst_n",  64'(core_rst_n),     64'(m_ph == PH_RUN));
        cmp("busy",        64'(busy),           64'(m_ph >= PH_LOAD && m_ph <= PH_RUN));
        cmp("done",        64'(done),           64'(m_ph == PH_DONE));
        cmp("dmem_we",     64'(dmem_we),        64'(e_dmem));
        cmp("imem_we",     64'(imem_we),        64'(m_we));
        cmp("imem_waddr",  64'(imem_waddr),     64'(m_wa));
        cmp("imem_wdata",  64'(imem_wdata),     64'(m_wd));
        cmp("timeout",     64'(timeout),        64'(m_to));
        cmp("overflow",    64'(overflow),       64'(m_ov));
        cmp("exit_code",   64'(exit_code),      64'(m_exit));
        cmp("cycle_count", 64'(cycle_count),    64'(m_cnt));
        if (RESET_N) m_step();
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_inputs();
        start = 0; abort = 0;
        lif.load_valid = 0; lif.load_data = '0; lif.load_last = 0;
        core_mem_write = 0; core_daddr = '0; core_ddata_w = '0;
    endtask

    task automatic send(input logic [31:0] d, input bit last);
        lif.load_valid = 1; lif.load_data = d; lif.load_last = last;
        tick();
        lif.load_valid = 0; lif.load_last = 0;
    endtask

    task automatic wait_count(input int v);
        for (int i = 0; i < 40 && cycle_count != CW'(v); i++) tick();
        cmp("reach_count", 64'(cycle_count), 64'(v));
    endtask

    task automatic begin_load();
        start = 1;
        tick();
        start = 0;
    endtask

    logic [31:0] prog [4] = '{32'h00500093, 32'h00100113, 32'h002081B3, 32'h3E302E23};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 0;
        clr_inputs();
        repeat (3) tick();
        cmp("rst_core_rst_n", 64'(core_rst_n), 64'(0));
        cmp("rst_busy", 64'(busy), 64'(0));
        cmp("rst_load_ready", 64'(lif.load_ready), 64'(0));
        RESET_N = 1;
        tick();

        // Four-word program, halt store at cycle 7.
        begin_load();
        cmp("load_ready_on", 64'(lif.load_ready), 64'(1));
        for (int i = 0; i < 4; i++) begin
            lif.load_valid = 1; lif.load_data = prog[i]; lif.load_last = (i == 3);
            tick();
            cmp("prog_we", 64'(imem_we), 64'(1));
            cmp("prog_addr", 64'(imem_waddr), 64'(i));
            cmp("prog_data", 64'(imem_wdata), 64'(prog[i]));
        end
        lif.load_valid = 0; lif.load_last = 0;
        cmp("release_ready", 64'(lif.load_ready), 64'(0));
        cmp("release_core_rst", 64'(core_rst_n), 64'(0));
        tick();
        cmp("run_core_rst", 64'(core_rst_n), 64'(1));
        cmp("run_count0", 64'(cycle_count), 64'(0));
        wait_count(3);
        core_mem_write = 1; core_daddr = 2'h1; core_ddata_w = 32'h77;
        #1;
        cmp("plain_store_we", 64'(dmem_we), 64'(1));
        tick();
        core_mem_write = 0;
        wait_count(7);
        core_mem_write = 1; core_daddr = HA; core_ddata_w = 32'h2A;
        #1;
        cmp("halt_store_we", 64'(dmem_we), 64'(0));
        tick();
        core_mem_write = 0;
        cmp("halt_done", 64'(done), 64'(1));
        cmp("halt_exit", 64'(exit_code), 64'(32'h2A));
        cmp("halt_count", 64'(cycle_count), 64'(8));
        cmp("halt_timeout", 64'(timeout), 64'(0));
        cmp("halt_core_rst", 64'(core_rst_n), 64'(0));

        // Valid gaps during load, then run to the cycle budget.
        begin_load();
        send(32'hA0, 0);
        cmp("gap_w0_addr", 64'(imem_waddr), 64'(0));
        tick();
        cmp("gap_no_we", 64'(imem_we), 64'(0));
        cmp("gap_ready", 64'(lif.load_ready), 64'(1));
        send(32'hB1, 0);
        cmp("gap_w1_addr", 64'(imem_waddr), 64'(1));
        tick();
        cmp("gap_no_we2", 64'(imem_we), 64'(0));
        send(32'hC2, 1);
        cmp("gap_w2_addr", 64'(imem_waddr), 64'(2));
        for (int i = 0; i < 40 && !done; i++) tick();
        cmp("to_done", 64'(done), 64'(1));
        cmp("to_timeout", 64'(timeout), 64'(1));
        cmp("to_count", 64'(cycle_count), 64'(16));
        cmp("to_core_rst", 64'(core_rst_n), 64'(0));

        // Halt coincident with the final budget cycle.
        begin_load();
        send(32'h1, 1);
        tick();
        wait_count(15);
        core_mem_write = 1; core_daddr = HA; core_ddata_w = 32'h55;
        tick();
        core_mem_write = 0;
        cmp("coin_timeout", 64'(timeout), 64'(0));
        cmp("coin_exit", 64'(exit_code), 64'(32'h55));
        cmp("coin_done", 64'(done), 64'(1));

        // Abort mid-load, with a word accepted in the abort cycle.
        begin_load();
        send(32'h11, 0);
        send(32'h22, 0);
        lif.load_valid = 1; lif.load_data = 32'h33; abort = 1;
        tick();
        lif.load_valid = 0; abort = 0;
        cmp("abort_ld_busy", 64'(busy), 64'(0));
        cmp("abort_ld_we", 64'(imem_we), 64'(0));
        cmp("abort_ld_core_rst", 64'(core_rst_n), 64'(0));
        begin_load();
        send(32'h1234, 1);
        cmp("restart_addr", 64'(imem_waddr), 64'(0));
        tick();
        wait_count(4);
        abort = 1;
        tick();
        abort = 0;
        cmp("abort_run_busy", 64'(busy), 64'(0));
        cmp("abort_run_core_rst", 64'(core_rst_n), 64'(0));
        cmp("abort_run_we", 64'(imem_we), 64'(0));
        begin_load();
        cmp("restart_count", 64'(cycle_count), 64'(0));
        cmp("restart_exit", 64'(exit_code), 64'(0));

        // Address wrap without last, then asynchronous reset during RUN.
        for (int i = 0; i < 4; i++) send(32'h100 + i, 0);
        cmp("ovf_flag", 64'(overflow), 64'(1));
        cmp("ovf_ready", 64'(lif.load_ready), 64'(0));
        cmp("ovf_busy", 64'(busy), 64'(1));
        tick();
        cmp("ovf_run", 64'(core_rst_n), 64'(1));
        wait_count(3);
        core_mem_write = 1; core_daddr = 2'h0;
        #2;
        RESET_N = 0;
        #1;
        cmp("arst_core_rst", 64'(core_rst_n), 64'(0));
        cmp("arst_busy", 64'(busy), 64'(0));
        cmp("arst_count", 64'(cycle_count), 64'(0));
        cmp("arst_overflow", 64'(overflow), 64'(0));
        cmp("arst_dmem_we", 64'(dmem_we), 64'(0));
        cmp("arst_done", 64'(done), 64'(0));
        clr_inputs();
        tick();
        tick();
        RESET_N = 1;
        tick();

        // Randomized episodes.
        for (int ep = 0; ep < 40; ep++) begin
            int nw;
            begin_load();
            nw = $urandom_range(1, 5);
            for (int i = 0; i < nw && lif.load_ready; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                lif.load_valid = 1;
                lif.load_data  = $urandom;
                lif.load_last  = (i == nw - 1);
                abort = ($urandom_range(0, 29) == 0);
                start = ($urandom_range(0, 9) == 0);
                tick();
                lif.load_valid = 0; lif.load_last = 0; abort = 0; start = 0;
            end
            for (int c = 0; c < 24 && busy; c++) begin
                core_mem_write = ($urandom_range(0, 2) == 0);
                core_daddr     = AW'($urandom);
                core_ddata_w   = $urandom;
                abort          = ($urandom_range(0, 39) == 0);
                start          = ($urandom_range(0, 7) == 0);
                tick();
            end
            clr_inputs();
            tick();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
